dpram_wr_arbiter: RTL and testbench

- Shares the single write port of a 16-bit, byte-enabled, dual-port video/shadow RAM between two requesters.
  - Requester 0: CPU bus bridge.
  - Requester 1: loader/DMA.
- Round-robin arbitration with a req/ack handshake.
- Built-in clear sequencer fills the whole RAM with a constant at reset-of-machine time.
- Sits between the requesters and the RAM write-port pins (wraddress, wren, byteena_a, data); the read port is untouched.

---
 rtl/dpram_wr_arbiter.sv | 123 ++++++++++++
 tb/tb_dpram_wr_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dpram_wr_arbiter.sv
// Write-port arbiter for a 16-bit byte-enabled dual-port RAM.
// Two requesters share the write port round-robin with a req/ack handshake.
// A built-in sequencer can fill words 0..NUMWORDS-1 with CLR_DATA.
module dpram_wr_arbiter #(
  parameter int          ADDRWIDTH = 14,
  parameter int          NUMWORDS  = 1 << ADDRWIDTH,
  parameter logic [15:0] CLR_DATA  = 16'h0000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req0,
  input  logic [ADDRWIDTH-1:0] addr0,
  input  logic [15:0]          data0,
  input  logic [1:0]           be0,
  output logic                 ack0,
  input  logic                 req1,
  input  logic [ADDRWIDTH-1:0] addr1,
  input  logic [15:0]          data1,
  input  logic [1:0]           be1,
  output logic                 ack1,
  input  logic                 clr_start,
  output logic                 clr_busy,
  output logic [ADDRWIDTH-1:0] ram_wraddress,
  output logic                 ram_wren,
  output logic [1:0]           ram_byteena,
  output logic [15:0]          ram_data
);

  typedef enum logic {IDLE, CLEAR} state_t;

  // One write beat as presented on the RAM pins.
  typedef struct packed {
    logic [ADDRWIDTH-1:0] addr;
    logic [15:0]          data;
    logic [1:0]           be;
  } wr_t;

  localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(NUMWORDS - 1);

  state_t               state_q, state_d;
  logic [ADDRWIDTH-1:0] cnt_q, cnt_d;
  logic                 last_q, last_d;    // 1: requester 1 was granted last
  wr_t                  wr_q, wr_d;
  logic                 wren_d, ack0_d, ack1_d, busy_d;
  logic                 elig0, elig1, grant0, grant1;

  // A requester whose ack is high this cycle is masked so the held-high
  // request is not mistaken for a fresh one.
  assign elig0  = req0 & ~ack0;
  assign elig1  = req1 & ~ack1;
  assign grant0 = elig0 & (~elig1 | last_q);
  assign grant1 = elig1 & (~elig0 | ~last_q);

  assign ram_wraddress = wr_q.addr;
  assign ram_data      = wr_q.data;
  assign ram_byteena   = wr_q.be;

  // Next-state and next-output decode; write fields hold unless overwritten.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    wr_d    = wr_q;
    wren_d  = 1'b0;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    busy_d  = clr_busy;
    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d = CLEAR;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end else if (grant0) begin
          wr_d   = '{addr: addr0, data: data0, be: be0};
          wren_d = 1'b1;
          ack0_d = 1'b1;
          last_d = 1'b0;
        end else if (grant1) begin
          wr_d   = '{addr: addr1, data: data1, be: be1};
          wren_d = 1'b1;
          ack1_d = 1'b1;
          last_d = 1'b1;
        end
      end
      CLEAR: begin
        wr_d   = '{addr: cnt_q, data: CLR_DATA, be: 2'b11};
        wren_d = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          // Final word issued: leave without wrapping the counter.
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + ADDRWIDTH'(1);
        end
      end
    endcase
  end

  // State and registered RAM-side outputs; reset aborts any clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      wr_q     <= '0;
      ram_wren <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      clr_busy <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      wr_q     <= wr_d;
      ram_wren <= wren_d;
      ack0     <= ack0_d;
      ack1     <= ack1_d;
      clr_busy <= busy_d;
    end
  end

endmodule

// File: tb/tb_dpram_wr_arbiter.sv
// Bench for dpram_wr_arbiter: directed scenarios with literal expectations
// plus a randomized phase, all cross-checked every cycle against a
// transaction-level model (clear modelled as a queue of pending addresses).
module tb_dpram_wr_arbiter;
  localparam int          AW = 6;
  localparam int          NW = 10;
  localparam logic [15:0] CD = 16'h1234;

  logic          clk = 1'b0, reset_n = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0, clr_start = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [15:0]   data0 = '0, data1 = '0;
  logic [1:0]    be0 = '0, be1 = '0;
  logic          ack0, ack1, clr_busy, ram_wren;
  logic [AW-1:0] ram_wraddress;
  logic [1:0]    ram_byteena;
  logic [15:0]   ram_data;

  dpram_wr_arbiter #(.ADDRWIDTH(AW), .NUMWORDS(NW), .CLR_DATA(CD)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .addr0(addr0), .data0(data0), .be0(be0), .ack0(ack0),
    .req1(req1), .addr1(addr1), .data1(data1), .be1(be1), .ack1(ack1),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .ram_wraddress(ram_wraddress), .ram_wren(ram_wren),
    .ram_byteena(ram_byteena), .ram_data(ram_data));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
  endtask

  // ---------------- reference model ----------------
  logic          e_ack0 = 0, e_ack1 = 0, e_busy = 0, e_wren = 0;
  logic [AW-1:0] e_addr = '0;
  logic [15:0]   e_data = '0;
  logic [1:0]    e_be = '0;
  int            last_g = 1;
  int            clr_q[$];
  int            win;

  always @(negedge reset_n) begin
    e_ack0 = 0; e_ack1 = 0; e_busy = 0; e_wren = 0;
    e_addr = '0; e_data = '0; e_be = '0; last_g = 1;
    clr_q.delete();
  end

  // Compare current outputs, then predict those after the coming edge.
  always @(negedge clk) begin
    chk("ack0", ack0, e_ack0);
    chk("ack1", ack1, e_ack1);
    chk("clr_busy", clr_busy, e_busy);
    chk("wren", ram_wren, e_wren);
    chk("wraddress", ram_wraddress, e_addr);
    chk("data", ram_data, e_data);
    chk("byteena", ram_byteena, e_be);
    if (reset_n) begin
      if (clr_q.size() != 0) begin
        e_addr = AW'(clr_q.pop_front());
        e_data = CD; e_be = 2'b11; e_wren = 1;
        e_ack0 = 0; e_ack1 = 0;
        e_busy = (clr_q.size() != 0);
      end else if (clr_start) begin
        for (int a = 0; a < NW; a++) clr_q.push_back(a);
        e_busy = 1; e_wren = 0; e_ack0 = 0; e_ack1 = 0;
      end else begin
        win = -1;
        if ((req0 && !e_ack0) && (req1 && !e_ack1)) win = (last_g == 0) ? 1 : 0;
        else if (req0 && !e_ack0) win = 0;
        else if (req1 && !e_ack1) win = 1;
        e_ack0 = (win == 0); e_ack1 = (win == 1); e_wren = (win >= 0);
        if (win == 0) begin e_addr = addr0; e_data = data0; e_be = be0; last_g = 0; end
        if (win == 1) begin e_addr = addr1; e_data = data1; e_be = be1; last_g = 1; end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(); @(posedge clk); #1; endtask
  task automatic do_reset(); reset_n = 0; tick(); tick(); reset_n = 1; endtask

  int seq[6] = '{0, 1, 0, 1, 0, 1};
  int cnt, cnt2, bad, first;
  logic [AW-1:0] cur;
  logic written[64];

  initial begin
    tick(); tick(); #1;
    chk("rst_wren", ram_wren, 0);
    chk("rst_busy", clr_busy, 0);
    reset_n = 1;

    // Single write with partial byte enable.
    tick(); req0 = 1; addr0 = 6'h12; data0 = 16'hBEEF; be0 = 2'b10;
    tick();
    chk("t1_ack0", ack0, 1); chk("t1_wren", ram_wren, 1);
    chk("t1_addr", ram_wraddress, 6'h12); chk("t1_data", ram_data, 16'hBEEF);
    chk("t1_be", ram_byteena, 2'b10);
    req0 = 0;
    tick(); chk("t1_wren_drop", ram_wren, 0);

    // Contention straight after reset: strict alternation starting with 0.
    do_reset();
    req0 = 1; addr0 = 6'h01; data0 = 16'hA0A0; be0 = 2'b11;
    req1 = 1; addr1 = 6'h02; data1 = 16'hB1B1; be1 = 2'b01;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t2_grant", ack1 ? 1 : (ack0 ? 0 : 7), seq[i]);
      chk("t2_not_both", ack0 & ack1, 0);
      chk("t2_wren", ram_wren, 1);
    end
    req0 = 0; req1 = 0;
    tick(); tick();

    // Single requester held high: one write every other cycle.
    req1 = 1; cur = 6'h20; addr1 = cur; data1 = 16'h5555; be1 = 2'b11; cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ack1) begin
        cnt++;
        chk("t3_addr", ram_wraddress, cur);
        cur = cur + 6'd3; addr1 = cur;
      end
    end
    req1 = 0;
    chk("t3_acks", cnt, 4);
    tick(); tick();

    // Full clear: 10 busy cycles, writes to 0..9 only.
    foreach (written[k]) written[k] = 0;
    clr_start = 1; tick(); clr_start = 0;
    cnt = 0; cnt2 = 0; bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (clr_busy) cnt++;
      tick();
      if (ram_wren) begin
        cnt2++; written[ram_wraddress] = 1;
        if (ram_data != CD || ram_byteena != 2'b11) bad++;
      end
    end
    foreach (written[k]) if (written[k] != (k < NW)) bad++;
    chk("t4_busy_cycles", cnt, NW);
    chk("t4_writes", cnt2, NW);
    chk("t4_content", bad, 0);
    chk("t4_busy_end", clr_busy, 0);

    // Request arriving with clr_start; second clr_start mid-clear ignored.
    // be=00 is still granted as a no-op write.
    req0 = 1; addr0 = 6'h33; data0 = 16'hCAFE; be0 = 2'b00; clr_start = 1;
    first = -1; cnt = 0;
    for (int k = 0; k <= 20; k++) begin
      tick();
      if (k == 0) clr_start = 0;
      if (k == 4) clr_start = 1;
      if (k == 5) clr_start = 0;
      if (ram_wren && !ack0) cnt++;
      if (ack0 && first < 0) begin
        first = k; req0 = 0;
        chk("t5_be00", ram_byteena, 2'b00);
        chk("t5_addr", ram_wraddress, 6'h33);
      end
    end
    chk("t5_first_ack", first, 11);
    chk("t5_clear_writes", cnt, NW);

    // Reset in the middle of a clear, then a fresh clear from address 0.
    clr_start = 1; tick(); clr_start = 0;
    bad = 1;
    for (int i = 0; i < 20 && bad; i++) begin
      tick();
      if (ram_wren && ram_wraddress == 6'd3) bad = 0;
    end
    chk("t6_reached_addr3", bad, 0);
    tick(); #2;
    reset_n = 0; #1;
    chk("t6_rst_busy", clr_busy, 0); chk("t6_rst_wren", ram_wren, 0);
    chk("t6_rst_addr", ram_wraddress, 0); chk("t6_rst_data", ram_data, 0);
    tick(); tick(); reset_n = 1;
    tick(); clr_start = 1; tick(); clr_start = 0;
    first = -1;
    for (int i = 0; i < 5 && first < 0; i++) begin
      tick();
      if (ram_wren) first = ram_wraddress;
    end
    chk("t6_restart_addr", first, 0);
    repeat (12) tick();

    // Randomized traffic obeying the requester hold rules.
    for (int i = 0; i < 600; i++) begin
      if (!(req0 && !ack0)) begin
        req0 = ($urandom_range(0, 9) < 6);
        addr0 = AW'($urandom); data0 = 16'($urandom); be0 = 2'($urandom);
      end
      if (!(req1 && !ack1)) begin
        req1 = ($urandom_range(0, 9) < 6);
        addr1 = AW'($urandom); data1 = 16'($urandom); be1 = 2'($urandom);
      end
      clr_start = ($urandom_range(0, 79) == 0);
      tick();
    end
    req0 = 0; req1 = 0; clr_start = 0;
    repeat (15) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
